mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction fetcher and the load/store path of the execute stage. It accepts one access at a time from either requester and drives a single non-pipelined synchronous memory with fixed latency MEM_LAT. It returns read data, or write completion, to the requester that issued the access. It sits between insn_fetcher / execute and the unified program/data memory, and uses the same valid/stall handshake as the pipeline stages.

## Interface
Parameters:
- ADDR_W, 16, memory word address width (equals MEM_INSN_ADDR)
- DATA_W, 16, memory word width (equals LEN_REG and LEN_INSN)
- MEM_LAT, 2, cycles from access start to valid m_rdata_i; legal range 1..15
- FETCH_GUARD, 4, maximum consecutive data grants while a fetch waits (only used with MEM_ARB_GUARD_EN)

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-low reset
- f_valid_i  in  1  fetch read request
- f_addr_i  in  ADDR_W  fetch address
- f_flush_i  in  1  taken branch: discard any outstanding fetch response
- f_stall_o  out  1  fetch request not accepted this cycle
- f_rvalid_o  out  1  one-cycle pulse, f_rdata_o valid
- f_rdata_o  out  DATA_W  fetched instruction word
- d_valid_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_stall_o  out  1  data request not accepted this cycle
- d_rvalid_o  out  1  one-cycle pulse: load data valid, or store done
- d_rdata_o  out  DATA_W  load data; 0 after a store
- m_en_o  out  1  memory access active
- m_we_o  out  1  memory write enable
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_rdata_i  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- A request is accepted in a cycle when valid_i=1 and stall_o=0. Acceptance is possible only in IDLE or RESP.
- Grant rule:
  - If only one requester is valid, it is granted.
  - If both are valid, data wins (it is the older instruction), subject to the guard.
  - The losing requester sees stall_o=1, combinationally.
- In ACCESS, both stall_o outputs equal their valid_i.
- On acceptance:
  - Latch owner, we, addr, wdata.
  - Load latency counter with MEM_LAT-1.
  - Go to ACCESS.
- In ACCESS:
  - m_en_o=1, and m_we_o/m_addr_o/m_wdata_o come from the latched values, held stable.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture m_rdata_i (zero for stores) and go to RESP.
- In RESP:
  - Pulse the owner's rvalid_o; the rdata_o of the owner holds the captured word until the next capture.
  - If a new request is accepted, go to ACCESS; otherwise go to IDLE.
- Flush:
  - f_flush_i=1 while the owner is fetch, in ACCESS or RESP, sets a drop flag that suppresses f_rvalid_o for that access.
  - The memory access itself completes normally.
  - f_flush_i in the same cycle as a new fetch acceptance does not affect the newly accepted request.
  - The drop flag clears on the next acceptance.
- Reset:
  - All outputs and state clear immediately, including mid-access: m_en_o=0, rvalid outputs 0, rdata outputs 0, counters 0.
  - Any in-flight access is abandoned; no response is issued.

## Timing
- Accept at edge T. m_en_o is high in cycles T+1..T+MEM_LAT. rvalid_o is high in cycle T+MEM_LAT+1.
- Load-to-use latency is MEM_LAT+1 cycles.
- Peak throughput is one access per MEM_LAT+1 cycles, because a request can be accepted in the RESP cycle.
- stall_o is combinational from valid_i and state. No other combinational path runs from input to output.

## Configuration
- MEM_ARB_GUARD_EN defined:
  - A counter counts consecutive data grants made while f_valid_i=1.
  - When it equals FETCH_GUARD, the next grant with both requesters valid goes to fetch, and the counter resets to 0.
  - The counter also resets on any fetch grant, and on any grant when f_valid_i=0.
- MEM_ARB_GUARD_EN undefined: strict data priority; fetch can starve; FETCH_GUARD is ignored.

## Structure
- Shared defs file: state encoding (ARB_IDLE, ARB_ACCESS, ARB_RESP) and owner encoding (ARB_OWN_F, ARB_OWN_D), alongside the existing insn defs.
- One sub-module is natural: mem_arb_guard, the saturating starvation counter. It is instantiated only under MEM_ARB_GUARD_EN.

## Test plan
- Single fetch, MEM_LAT=2, addr 0x0010, memory returns 0xA5A5 → f_rvalid_o pulses 3 cycles after acceptance with f_rdata_o=0xA5A5; d_rvalid_o stays 0.
- Simultaneous fetch 0x0020 and store 0x0100←0x1234 → store granted first with m_we_o=1; fetch stalled; fetch accepted in the store's RESP cycle; both responses returned.
- MEM_ARB_GUARD_EN, FETCH_GUARD=4, data and fetch both held valid → grant order is D,D,D,D,F,D,D,D,D,F; without the macro, fetch is never granted.
- f_flush_i pulsed in the ACCESS cycle of a fetch → no f_rvalid_o pulse; the next fetch's response is delivered normally.
- rst asserted in the middle of ACCESS of a load → m_en_o drops immediately; no d_rvalid_o after reset release; FSM is in IDLE.
- MEM_LAT=1 back-to-back loads → d_rvalid_o pulses every 2 cycles with correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared instruction/memory widths plus the arbiter FSM and owner encodings.
package mem_arbiter_pkg;

    localparam int MEM_INSN_ADDR = 16;
    localparam int LEN_INSN      = 16;
    localparam int ARB_CNT_W     = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_F = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_own_t;

    // Latency counter preload: ACCESS lasts lat cycles, counting down to zero.
    function automatic logic [ARB_CNT_W-1:0] arb_lat_load(input int lat);
        return ARB_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arb_guard.sv
// Fetch anti-starvation counter: saturates after FETCH_GUARD data grants made while fetch waits.
// Present only when MEM_ARB_GUARD_EN is defined.
`ifdef MEM_ARB_GUARD_EN
module mem_arb_guard #(
    parameter int FETCH_GUARD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_accept,
    input  logic i_grant_f,
    input  logic i_f_valid,
    output logic o_force_f
);

    localparam int GW = $clog2(FETCH_GUARD + 1);

    logic [GW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_accept) begin
            if (i_grant_f || !i_f_valid) begin
                r_cnt <= '0;
            end else if (r_cnt != GW'(FETCH_GUARD)) begin
                r_cnt <= r_cnt + GW'(1);
            end
        end
    end

    assign o_force_f = (r_cnt == GW'(FETCH_GUARD));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store; data wins ties.
// Defining MEM_ARB_GUARD_EN adds a fetch anti-starvation guard (mem_arb_guard).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = MEM_INSN_ADDR,
    parameter int DATA_W      = LEN_INSN,
    parameter int MEM_LAT     = 2,
    parameter int FETCH_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    input  logic              f_flush_i,
    output logic              f_stall_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              d_valid_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_stall_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    arb_own_t              r_own;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [ARB_CNT_W-1:0]  r_cnt;
    logic                  r_drop;
    logic                  r_f_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_W-1:0]     r_f_rdata;
    logic [DATA_W-1:0]     r_d_rdata;

    logic w_can_acc;
    logic w_force_f;
    logic w_grant_d;
    logic w_grant_f;
    logic w_accept;
    logic w_done;

    // New accesses start only when the memory is not busy (IDLE or the RESP cycle).
    assign w_can_acc = (r_state != ARB_ACCESS);
    assign w_grant_d = w_can_acc & d_valid_i & ~(f_valid_i & w_force_f);
    assign w_grant_f = w_can_acc & f_valid_i & ~w_grant_d;
    assign w_accept  = w_grant_d | w_grant_f;
    assign w_done    = (r_state == ARB_ACCESS) && (r_cnt == '0);

`ifdef MEM_ARB_GUARD_EN
    mem_arb_guard #(
        .FETCH_GUARD (FETCH_GUARD)
    ) u_guard (
        .clk       (clk),
        .rst       (rst),
        .i_accept  (w_accept),
        .i_grant_f (w_grant_f),
        .i_f_valid (f_valid_i),
        .o_force_f (w_force_f)
    );
`else
    // Strict data priority: the guard threshold has no effect in this build.
    assign w_force_f = (FETCH_GUARD < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        f_stall_o   = f_valid_i & ~w_grant_f;
        d_stall_o   = d_valid_i & ~w_grant_d;
        m_en_o      = 1'b0;
        m_we_o      = 1'b0;
        m_addr_o    = r_addr;
        m_wdata_o   = r_wdata;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                m_en_o = 1'b1;
                m_we_o = r_we;
                if (w_done) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_state_nxt = w_accept ? ARB_ACCESS : ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_own   <= ARB_OWN_F;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_own   <= w_grant_d ? ARB_OWN_D : ARB_OWN_F;
                r_we    <= w_grant_d & d_we_i;
                r_addr  <= w_grant_d ? d_addr_i : f_addr_i;
                r_wdata <= w_grant_d ? d_wdata_i : '0;
                r_cnt   <= arb_lat_load(MEM_LAT);
            end else if ((r_state == ARB_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - ARB_CNT_W'(1);
            end
            // A flush concurrent with a fresh fetch acceptance belongs to the older fetch.
            if (w_accept) begin
                r_drop <= 1'b0;
            end else if (f_flush_i && (r_own == ARB_OWN_F) && (r_state != ARB_IDLE)) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_f_rvalid <= w_done && (r_own == ARB_OWN_F) && !r_drop && !f_flush_i;
            r_d_rvalid <= w_done && (r_own == ARB_OWN_D);
            if (w_done && (r_own == ARB_OWN_F)) begin
                r_f_rdata <= m_rdata_i;
            end
            if (w_done && (r_own == ARB_OWN_D)) begin
                r_d_rdata <= r_we ? '0 : m_rdata_i;
            end
        end
    end

    assign f_rvalid_o = r_f_rvalid;
    assign f_rdata_o  = r_f_rdata;
    assign d_rvalid_o = r_d_rvalid;
    assign d_rdata_o  = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a MEM_LAT=2 instance for the main scenarios and a MEM_LAT=1 instance for back-to-back loads.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int FG  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        f_valid = 1'b0, f_flush = 1'b0, d_valid = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic        f_stall, f_rvalid, d_stall, d_rvalid, m_en, m_we;
    logic [15:0] f_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        b_valid = 1'b0;
    logic [15:0] b_addr = '0;
    logic        b_f_stall, b_f_rvalid, b_stall, b_rvalid, b_m_en, b_m_we;
    logic [15:0] b_f_rdata, b_rdata, b_m_addr, b_m_wdata, b_m_rdata;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .FETCH_GUARD(FG)) u_dut (
        .clk(clk), .rst(rst),
        .f_valid_i(f_valid), .f_addr_i(f_addr), .f_flush_i(f_flush), .f_stall_o(f_stall),
        .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .d_valid_i(d_valid), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_stall_o(d_stall), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .FETCH_GUARD(FG)) u_dut1 (
        .clk(clk), .rst(rst),
        .f_valid_i(1'b0), .f_addr_i(16'h0000), .f_flush_i(1'b0), .f_stall_o(b_f_stall),
        .f_rvalid_o(b_f_rvalid), .f_rdata_o(b_f_rdata),
        .d_valid_i(b_valid), .d_we_i(1'b0), .d_addr_i(b_addr), .d_wdata_i(16'h0000),
        .d_stall_o(b_stall), .d_rvalid_o(b_rvalid), .d_rdata_o(b_rdata),
        .m_en_o(b_m_en), .m_we_o(b_m_we), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata),
        .m_rdata_i(b_m_rdata)
    );

    // Memory model: read data is valid throughout the access window.
    assign m_rdata   = m_en   ? mem[m_addr[9:0]]   : 16'h0000;
    assign b_m_rdata = b_m_en ? mem[b_m_addr[9:0]] : 16'h0000;
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr[9:0]] <= m_wdata;
    end

    function automatic logic [15:0] init_val(input int i);
        if (i == 16'h0010) return 16'hA5A5;
        return 16'(i * 257) ^ 16'h3C5A;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [15:0] data;
        bit          drop;
    } exp_t;

    exp_t qf[$], qd[$], qb[$];
    byte  g_log[$];
    int   g_cyc[$];
    int   cyc = 0;
    int   acc_start = -1000;
    int   b_last = -1;
    logic        cur_we;
    logic [15:0] cur_addr, cur_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        logic exp_en;
        if (rst) begin
            if (qf.size() > 0 && qf[0].cyc == cyc) begin
                e = qf.pop_front();
                if (e.drop) begin
                    check_eq("f_dropped_rvalid", f_rvalid, 0);
                end else begin
                    check_eq("f_rvalid", f_rvalid, 1);
                    check_eq("f_rdata", f_rdata, e.data);
                end
            end else if (f_rvalid) begin
                check_eq("f_spurious_rvalid", f_rvalid, 0);
            end
            if (qd.size() > 0 && qd[0].cyc == cyc) begin
                e = qd.pop_front();
                check_eq("d_rvalid", d_rvalid, 1);
                check_eq("d_rdata", d_rdata, e.data);
            end else if (d_rvalid) begin
                check_eq("d_spurious_rvalid", d_rvalid, 0);
            end
            exp_en = (cyc >= acc_start) && (cyc < acc_start + LAT);
            if (m_en !== exp_en) check_eq("m_en_window", m_en, exp_en);
            if (m_en && exp_en) begin
                check_eq("m_we", m_we, cur_we);
                check_eq("m_addr", m_addr, cur_addr);
                if (cur_we) check_eq("m_wdata", m_wdata, cur_wdata);
            end
            if (f_flush && qf.size() > 0 && qf[0].cyc > cyc) qf[0].drop = 1'b1;
            if (d_valid && !d_stall && f_valid && !f_stall) check_eq("double_grant", f_stall, 1);
            if (d_valid && !d_stall) begin
                e.cyc = cyc + 1 + LAT;
                e.drop = 1'b0;
                if (d_we) begin
                    e.data = 16'h0000;
                    ref_mem[d_addr[9:0]] = d_wdata;
                end else begin
                    e.data = ref_mem[d_addr[9:0]];
                end
                qd.push_back(e);
                g_log.push_back("D");
                g_cyc.push_back(cyc);
                acc_start = cyc + 1;
                cur_we = d_we; cur_addr = d_addr; cur_wdata = d_wdata;
            end else if (f_valid && !f_stall) begin
                e.cyc = cyc + 1 + LAT;
                e.drop = 1'b0;
                e.data = ref_mem[f_addr[9:0]];
                qf.push_back(e);
                g_log.push_back("F");
                g_cyc.push_back(cyc);
                acc_start = cyc + 1;
                cur_we = 1'b0; cur_addr = f_addr; cur_wdata = 16'h0000;
            end
            if (qb.size() > 0 && qb[0].cyc == cyc) begin
                e = qb.pop_front();
                check_eq("b_rvalid", b_rvalid, 1);
                check_eq("b_rdata", b_rdata, e.data);
            end else if (b_rvalid) begin
                check_eq("b_spurious_rvalid", b_rvalid, 0);
            end
            if (b_valid && !b_stall) begin
                e.cyc = cyc + 2;
                e.drop = 1'b0;
                e.data = ref_mem[b_addr[9:0]];
                qb.push_back(e);
                if (b_last >= 0) check_eq("b_accept_spacing", cyc - b_last, 2);
                b_last = cyc;
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a);
        int n = 0;
        f_valid = 1'b1;
        f_addr  = a;
        @(negedge clk);
        while (f_stall && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (f_stall) check_eq("f_accept_timeout", f_stall, 0);
        @(posedge clk); #1;
        f_valid = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
        int n = 0;
        d_valid = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        @(negedge clk);
        while (d_stall && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (d_stall) check_eq("d_accept_timeout", d_stall, 0);
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        string exp_order;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end

        // Reset state
        #3;
        check_eq("rst_m_en", m_en, 0);
        check_eq("rst_f_rvalid", f_rvalid, 0);
        check_eq("rst_d_rvalid", d_rvalid, 0);
        check_eq("rst_f_rdata", f_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_b_rvalid", b_rvalid, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        idle(2);

        // Single fetch
        do_fetch(16'h0010);
        idle(6);
        check_eq("f_rdata_hold", f_rdata, 16'hA5A5);

        // Simultaneous fetch and store: store first, fetch in store's RESP cycle
        base = g_log.size();
        fork
            do_fetch(16'h0020);
            do_data(1'b1, 16'h0100, 16'h1234);
        join
        idle(6);
        check_eq("order_store_first", g_log[base], "D");
        check_eq("order_fetch_second", g_log[base+1], "F");
        check_eq("fetch_in_resp", g_cyc[base+1] - g_cyc[base], LAT + 1);
        check_eq("d_rdata_after_store", d_rdata, 0);
        do_data(1'b0, 16'h0100, 16'h0000);
        idle(5);

        // Flush during ACCESS drops the response; next fetch is delivered
        do_fetch(16'h0030);
        f_flush = 1'b1;
        @(posedge clk); #1;
        f_flush = 1'b0;
        idle(5);
        do_fetch(16'h0040);
        idle(5);

        // Flush in the acceptance cycle does not affect the new fetch
        fork
            begin
                f_flush = 1'b1;
                @(posedge clk); #1;
                f_flush = 1'b0;
            end
            do_fetch(16'h0041);
        join
        idle(5);

        // Contention: data and fetch held valid
        base = g_log.size();
`ifdef MEM_ARB_GUARD_EN
        exp_order = "DDDDFDDDDF";
        fork
            for (int k = 0; k < 8; k++) do_data(1'b0, 16'h0300 + 16'(k), 16'h0000);
            for (int k = 0; k < 2; k++) do_fetch(16'h0050 + 16'(k));
        join
`else
        exp_order = "DDDDDDDDDD";
        fork
            for (int k = 0; k < 10; k++) do_data(1'b0, 16'h0300 + 16'(k), 16'h0000);
            for (int k = 0; k < 2; k++) do_fetch(16'h0050 + 16'(k));
        join
`endif
        idle(6);
        for (int k = 0; k < 10; k++) check_eq($sformatf("grant_%0d", k), g_log[base+k], exp_order[k]);

        // Reset in the middle of a load's ACCESS phase
        do_data(1'b0, 16'h0060, 16'h0000);
        #2;
        rst = 1'b0;
        qf.delete(); qd.delete(); qb.delete();
        acc_start = -1000;
        #1;
        check_eq("midrst_m_en", m_en, 0);
        check_eq("midrst_d_rvalid", d_rvalid, 0);
        check_eq("midrst_d_rdata", d_rdata, 0);
        check_eq("midrst_f_rdata", f_rdata, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        idle(6);
        d_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0061;
        @(negedge clk);
        check_eq("post_rst_idle_accept", d_stall, 0);
        @(posedge clk); #1;
        d_valid = 1'b0;
        idle(5);

        // MEM_LAT=1 back-to-back loads
        b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int n;
            n = 0;
            b_addr = 16'h0200 + 16'(i);
            @(negedge clk);
            while (b_stall && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (b_stall) check_eq("b_accept_timeout", b_stall, 0);
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        idle(6);

        check_eq("f_queue_drained", qf.size(), 0);
        check_eq("d_queue_drained", qd.size(), 0);
        check_eq("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
